// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: bus bundle between the core data port and dmem_mmio.
//   addr/memWrite/writeData/writeStrobe : core store/load request
//   readData                            : combinational load data
//   tx_data/tx_valid/tx_ready           : console TX FIFO drain handshake
//   timer_irq                           : machine timer level interrupt
// master = core/consumer side, slave = dmem_mmio.
interface dmem_mmio_if;
    logic [31:0] addr;
    logic        memWrite;
    logic [31:0] writeData;
    logic [3:0]  writeStrobe;
    logic [31:0] readData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    modport master (
        output addr, memWrite, writeData, writeStrobe, tx_ready,
        input  readData, tx_data, tx_valid, timer_irq
    );

    modport slave (
        input  addr, memWrite, writeData, writeStrobe, tx_ready,
        output readData, tx_data, tx_valid, timer_irq
    );
endinterface

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory subsystem behind the single-cycle core.
//   Byte-strobed data RAM at 0 .. DEPTH_WORDS*4-1, MMIO block at MMIO_BASE
//   (console TX FIFO + STATUS, optional 64-bit machine timer).
// Ports:
//   clk   : core clock
//   reset : synchronous, active-high
//   bus   : dmem_mmio_if.slave (core request, readData, TX drain, timer_irq)
// Build option: define DMEM_TIMER_EN to include the mtime/mtimecmp timer;
//   without it the timer offsets read 0, ignore writes and timer_irq is 0.
// MMIO offsets: 0x00 TXDATA, 0x04 STATUS, 0x08/0x0C MTIME, 0x10/0x14 MTIMECMP.
module dmem_mmio #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input logic        clk,
    input logic        reset,
    dmem_mmio_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] word_idx;
    logic [7:0]    off;

    assign ram_hit  = bus.addr < RAM_BYTES;
    assign mmio_hit = bus.addr[31:8] == MMIO_BASE[31:8];
    assign word_idx = bus.addr[AW+1:2];
    assign off      = bus.addr[7:0];

    // ---------------- data RAM (contents not reset) ----------------
    logic [31:0] ram [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (!reset && bus.memWrite && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.writeStrobe[b]) ram[word_idx][8*b +: 8] <= bus.writeData[8*b +: 8];
            end
        end
    end

    // ---------------- console TX FIFO ----------------
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          full, empty, pop, push_req, push_ok, ovf_clr;
    logic [4:0]    count5;

    assign full     = count == CW'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign pop      = !empty && bus.tx_ready;
    assign push_req = bus.memWrite && mmio_hit && off == 8'h00 && bus.writeStrobe[0];
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_clr  = bus.memWrite && mmio_hit && off == 8'h04 && bus.writeStrobe[0]
                      && bus.writeData[2];
    assign count5   = 5'(count);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= bus.writeData[7:0];
    end

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 8'h00 : fifo[rd_ptr];

    // ---------------- machine timer ----------------
`ifdef DMEM_TIMER_EN
    logic [63:0] mtime, mtimecmp, mtime_nxt, mtimecmp_nxt;
    logic        timer_irq_q;

    // Written lanes override the incremented value; unwritten lanes (and the
    // other half, carry included) keep counting.
    always_comb begin
        mtime_nxt    = mtime + 64'd1;
        mtimecmp_nxt = mtimecmp;
        if (bus.memWrite && mmio_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.writeStrobe[b]) begin
                    case (off)
                        8'h08:   mtime_nxt[8*b +: 8]         = bus.writeData[8*b +: 8];
                        8'h0C:   mtime_nxt[32+8*b +: 8]      = bus.writeData[8*b +: 8];
                        8'h10:   mtimecmp_nxt[8*b +: 8]      = bus.writeData[8*b +: 8];
                        8'h14:   mtimecmp_nxt[32+8*b +: 8]   = bus.writeData[8*b +: 8];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            timer_irq_q <= 1'b0;
        end else begin
            mtime       <= mtime_nxt;
            mtimecmp    <= mtimecmp_nxt;
            // Compare the values being loaded so irq tracks the registers.
            timer_irq_q <= mtime_nxt >= mtimecmp_nxt;
        end
    end

    assign bus.timer_irq = timer_irq_q;
`else
    assign bus.timer_irq = 1'b0;
`endif

    // ---------------- read mux ----------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = ram[word_idx];
        end else if (mmio_hit) begin
            case (off)
                8'h04:   rdata = {23'b0, count5, 1'b0, overflow, empty, full};
`ifdef DMEM_TIMER_EN
                8'h08:   rdata = mtime[31:0];
                8'h0C:   rdata = mtime[63:32];
                8'h10:   rdata = mtimecmp[31:0];
                8'h14:   rdata = mtimecmp[63:32];
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign bus.readData = rdata;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed + randomized bench for dmem_mmio against a
// queue/array reference model. Timer expectations follow DMEM_TIMER_EN.
module tb_dmem_mmio;
    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] STAT = BASE + 32'h04;
    localparam logic [31:0] MTL  = BASE + 32'h08;
    localparam logic [31:0] MTH  = BASE + 32'h0C;
    localparam logic [31:0] CML  = BASE + 32'h10;
    localparam logic [31:0] CMH  = BASE + 32'h14;
`ifdef DMEM_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    dmem_mmio_if bus ();

    dmem_mmio #(.DEPTH_WORDS(1024), .FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    byte unsigned q[$];
    bit           ovf;
    logic [63:0]  m_mtime;
    logic [63:0]  m_cmp;
    logic [31:0]  ram_m [1024];
    logic [3:0]   known [1024];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_reg(input logic [31:0] a);
        case (a)
            STAT:    return {23'b0, 5'(q.size()), 1'b0, ovf, q.size() == 0, q.size() == DEPTH};
            MTL:     return TMR ? m_mtime[31:0]  : 32'h0;
            MTH:     return TMR ? m_mtime[63:32] : 32'h0;
            CML:     return TMR ? m_cmp[31:0]    : 32'h0;
            CMH:     return TMR ? m_cmp[63:32]   : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // Apply the current inputs to the model, clock once, then check outputs.
    task automatic step();
        int sz;
        bit pop;
        int idx;
        sz = q.size();
        if (reset) begin
            q.delete();
            ovf     = 1'b0;
            m_mtime = 64'h0;
            m_cmp   = '1;
        end else begin
            pop = (sz > 0) && bus.tx_ready;
            if (pop) void'(q.pop_front());
            if (bus.memWrite && bus.addr == TXD && bus.writeStrobe[0]) begin
                if (sz < DEPTH || pop) q.push_back(bus.writeData[7:0]);
                else ovf = 1'b1;
            end
            if (bus.memWrite && bus.addr == STAT && bus.writeStrobe[0] && bus.writeData[2])
                ovf = 1'b0;
            if (bus.memWrite && bus.addr < 32'd4096) begin
                idx = int'(bus.addr[11:2]);
                for (int b = 0; b < 4; b++) begin
                    if (bus.writeStrobe[b]) begin
                        ram_m[idx][8*b +: 8] = bus.writeData[8*b +: 8];
                        known[idx][b] = 1'b1;
                    end
                end
            end
            m_mtime = m_mtime + 64'd1;
            if (bus.memWrite) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.writeStrobe[b]) begin
                        if (bus.addr == MTL) m_mtime[8*b +: 8]    = bus.writeData[8*b +: 8];
                        if (bus.addr == MTH) m_mtime[32+8*b +: 8] = bus.writeData[8*b +: 8];
                        if (bus.addr == CML) m_cmp[8*b +: 8]      = bus.writeData[8*b +: 8];
                        if (bus.addr == CMH) m_cmp[32+8*b +: 8]   = bus.writeData[8*b +: 8];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("tx_valid", 64'(bus.tx_valid), 64'(q.size() > 0));
        chk("tx_data", 64'(bus.tx_data), (q.size() > 0) ? 64'(q[0]) : 64'h0);
        chk("timer_irq", 64'(bus.timer_irq), 64'(TMR && (m_mtime >= m_cmp)));
    endtask

    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d,
                         input logic [3:0] s);
        bus.addr        = a;
        bus.memWrite    = we;
        bus.writeData   = d;
        bus.writeStrobe = s;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        drive(a, 1'b1, d, s);
        step();
        bus.memWrite = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr     = a;
        bus.memWrite = 1'b0;
        #1;
        chk(tag, 64'(bus.readData), 64'(exp));
    endtask

    task automatic chk_ram(input string tag, input int idx);
        logic [31:0] mask;
        mask = {{8{known[idx][3]}}, {8{known[idx][2]}}, {8{known[idx][1]}}, {8{known[idx][0]}}};
        bus.addr     = 32'(idx) << 2;
        bus.memWrite = 1'b0;
        #1;
        chk(tag, 64'(bus.readData & mask), 64'(ram_m[idx] & mask));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            known[i] = 4'h0;
            ram_m[i] = 32'h0;
        end
        drive(32'h0, 1'b0, 32'h0, 4'h0);
        bus.tx_ready = 1'b0;

        // ---- reset state ----
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'h0);
        chk("rst_tx_data", 64'(bus.tx_data), 64'h0);
        chk("rst_irq", 64'(bus.timer_irq), 64'h0);
        chk_rd("rst_status", STAT, 32'h0000_0002);

        // ---- byte-strobed RAM ----
        wr(32'h44, 32'h1234_5678, 4'b1111);
        wr(32'h40, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h40, 32'h0000_00AA, 4'b0001);
        chk_rd("ram_strobe", 32'h40, 32'hDEAD_BEAA);
        chk_rd("ram_neighbour", 32'h44, 32'h1234_5678);
        chk_rd("ram_unaligned", 32'h43, 32'hDEAD_BEAA);
        wr(32'h48, 32'hCAFE_F00D, 4'b0000);
        chk_rd("ram_nostrobe", 32'h44, 32'h1234_5678);
        wr(32'h2000_0040, 32'hFFFF_FFFF, 4'b1111);
        chk_rd("unmapped_read", 32'h2000_0040, 32'h0);
        chk_rd("ram_after_unmapped", 32'h40, 32'hDEAD_BEAA);
        chk_rd("txdata_reads0", TXD, 32'h0);

        // ---- fill, overflow, W1C, drain ----
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) wr(TXD, 32'(i), 4'b0001);
        chk_rd("status_full", STAT, 32'h0000_0081);
        wr(TXD, 32'h09, 4'b0001);
        chk_rd("status_ovf", STAT, 32'h0000_0085);
        wr(STAT, 32'h4, 4'b0010);
        chk_rd("w1c_nostrobe", STAT, 32'h0000_0085);
        wr(STAT, 32'h4, 4'b0001);
        chk_rd("w1c_clear", STAT, 32'h0000_0081);
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", 64'(bus.tx_data), 64'(i));
            step();
        end
        chk("drain_empty", 64'(bus.tx_valid), 64'h0);
        chk_rd("status_empty", STAT, 32'h0000_0002);

        // ---- full FIFO with simultaneous push and pop ----
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(TXD, 32'h31 + 32'(i), 4'b0001);
        bus.tx_ready = 1'b1;
        wr(TXD, 32'h55, 4'b0001);
        bus.tx_ready = 1'b0;
        chk_rd("full_pushpop", STAT, 32'h0000_0081);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("pushpop_order", 64'(bus.tx_data), (i == 7) ? 64'h55 : 64'(32'h32 + 32'(i)));
            step();
        end
        chk("pushpop_empty", 64'(bus.tx_valid), 64'h0);
        bus.tx_ready = 1'b0;

        // ---- timer ----
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef DMEM_TIMER_EN
        wr(CMH, 32'h0, 4'b1111);
        wr(CML, 32'd20, 4'b1111);
        for (int i = 0; i < 60 && !bus.timer_irq; i++) step();
        chk("irq_rise", 64'(bus.timer_irq), 64'h1);
        chk_rd("irq_mtime", MTL, 32'd20);
        wr(CML, 32'hFFFF_FFFF, 4'b1111);
        wr(CMH, 32'hFFFF_FFFF, 4'b1111);
        chk("irq_drop", 64'(bus.timer_irq), 64'h0);
        wr(MTL, 32'hFFFF_FFFE, 4'b1111);
        wr(MTH, 32'h0, 4'b1111);
        chk_rd("mtime_lo_pre", MTL, 32'hFFFF_FFFF);
        chk_rd("mtime_hi_pre", MTH, 32'h0);
        step();
        chk_rd("mtime_lo_wrap", MTL, 32'h0);
        chk_rd("mtime_hi_carry", MTH, 32'h1);
        wr(CML, 32'hAABB_CCDD, 4'b0100);
        chk_rd("cmp_byte_strobe", CML, 32'hFFBB_FFFF);
`else
        wr(MTL, 32'h1234_5678, 4'b1111);
        chk_rd("notimer_mtl", MTL, 32'h0);
        wr(CML, 32'h0, 4'b1111);
        wr(CMH, 32'h0, 4'b1111);
        chk_rd("notimer_cml", CML, 32'h0);
        chk("notimer_irq", 64'(bus.timer_irq), 64'h0);
`endif

        // ---- reset with queued bytes and a store in flight ----
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(TXD, 32'hA0 + 32'(i), 4'b0001);
        wr(32'h80, 32'h1111_1111, 4'b1111);
        drive(32'h80, 1'b1, 32'h2222_2222, 4'b1111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.memWrite = 1'b0;
        chk("rst_mid_valid", 64'(bus.tx_valid), 64'h0);
        chk_rd("rst_mid_status", STAT, 32'h0000_0002);
        chk_rd("rst_mid_store", 32'h80, 32'h1111_1111);
        chk_rd("rst_mid_mtl", MTL, TMR ? 32'h0 : 32'h0);

        // ---- randomized traffic against the model ----
        for (int it = 0; it < 300; it++) begin
            int unsigned op;
            int idx;
            logic [31:0] ta;
            op = $urandom_range(0, 9);
            bus.tx_ready = 1'($urandom_range(0, 1));
            reset = (it % 97 == 50);
            case (op)
                0, 1, 2, 3: drive(32'($urandom_range(0, 15)) << 2, 1'b1, $urandom,
                                  4'($urandom_range(0, 15)));
                4, 5, 6:    drive(TXD, 1'b1, $urandom, 4'($urandom_range(0, 15)));
                7:          drive(STAT, 1'b1, $urandom, 4'($urandom_range(0, 15)));
                8:          drive(MTL + (32'($urandom_range(0, 3)) << 2), 1'b1, $urandom,
                                  4'($urandom_range(0, 15)));
                default:    drive(32'h2000_0000, 1'b1, $urandom, 4'hF);
            endcase
            step();
            reset = 1'b0;
            bus.memWrite = 1'b0;
            idx = $urandom_range(0, 15);
            if (known[idx] != 4'h0) chk_ram("rand_ram", idx);
            chk_rd("rand_status", STAT, exp_reg(STAT));
            ta = MTL + (32'($urandom_range(0, 3)) << 2);
            chk_rd("rand_timer", ta, exp_reg(ta));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
